// File: rtl/bit_fifo_tx_scheduler.sv
// Read-side drain controller for the single-bit transmit FIFO: frames buffered bits
// as start | payload LSB-first | optional even parity | stop onto a registered line.
//
// state  | meaning
// IDLE   | line high, waiting for tx enable and a whole payload in the FIFO
// START  | start bit (0) on the line
// DATA   | payload bits being loaded from the FIFO, one per tick
// PARITY | even-parity bit on the line
// STOP   | stop bit (1) on the line; may chain directly into the next START
module bit_fifo_tx_scheduler #(
   parameter int DEPTH      = 8,
   parameter int PTR_WIDTH  = 3,
   parameter int FRAME_BITS = 4,
   parameter int PARITY_EN  = 1
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_n,
   input  logic                 i_Tx_en,
   input  logic                 i_Bit_tick,
   input  logic [PTR_WIDTH:0]   i_b_wptr,
   input  logic                 i_Fifo_data,
   output logic [PTR_WIDTH:0]   o_b_rptr,
   output logic                 o_R_en,
   output logic                 o_empty,
   output logic [PTR_WIDTH:0]   o_Count,
   output logic                 o_Tx_line,
   output logic                 o_Busy,
   output logic                 o_Frame_done
);

   if (DEPTH != (1 << PTR_WIDTH) || FRAME_BITS < 1 || FRAME_BITS > DEPTH) begin : g_bad_params
      $error("bit_fifo_tx_scheduler: illegal DEPTH/PTR_WIDTH/FRAME_BITS combination");
   end

   localparam logic [PTR_WIDTH:0] FRAME_LEN = FRAME_BITS[PTR_WIDTH:0];
   localparam logic [PTR_WIDTH:0] ONE       = {{PTR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state;
   logic [PTR_WIDTH:0]   bit_cnt;
   logic                 parity;
   logic                 eligible;

   assign o_Count  = i_b_wptr - o_b_rptr;
   assign o_empty  = (o_Count == '0);
   assign eligible = i_Tx_en && (o_Count >= FRAME_LEN);

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state        <= S_IDLE;
         o_b_rptr     <= '0;
         o_R_en       <= 1'b0;
         o_Tx_line    <= 1'b1;
         o_Busy       <= 1'b0;
         o_Frame_done <= 1'b0;
         bit_cnt      <= '0;
         parity       <= 1'b0;
      end else begin
         o_R_en       <= 1'b0;
         o_Frame_done <= 1'b0;
         if (i_Bit_tick) begin
            case (state)
               S_IDLE: begin
                  if (eligible) begin
                     state     <= S_START;
                     o_Tx_line <= 1'b0;
                     o_Busy    <= 1'b1;
                     bit_cnt   <= '0;
                     parity    <= 1'b0;
                  end
               end
               S_START: begin
                  // The start-bit tick already loads payload bit 0.
                  state     <= S_DATA;
                  o_Tx_line <= i_Fifo_data;
                  parity    <= parity ^ i_Fifo_data;
                  o_b_rptr  <= o_b_rptr + ONE;
                  o_R_en    <= 1'b1;
                  bit_cnt   <= bit_cnt + ONE;
               end
               S_DATA: begin
                  if (bit_cnt < FRAME_LEN) begin
                     o_Tx_line <= i_Fifo_data;
                     parity    <= parity ^ i_Fifo_data;
                     o_b_rptr  <= o_b_rptr + ONE;
                     o_R_en    <= 1'b1;
                     bit_cnt   <= bit_cnt + ONE;
                  end else if (PARITY_EN != 0) begin
                     state     <= S_PARITY;
                     o_Tx_line <= parity;
                  end else begin
                     state     <= S_STOP;
                     o_Tx_line <= 1'b1;
                  end
               end
               S_PARITY: begin
                  state     <= S_STOP;
                  o_Tx_line <= 1'b1;
               end
               S_STOP: begin
                  o_Frame_done <= 1'b1;
                  if (eligible) begin
                     state     <= S_START;
                     o_Tx_line <= 1'b0;
                     bit_cnt   <= '0;
                     parity    <= 1'b0;
                  end else begin
                     state     <= S_IDLE;
                     o_Tx_line <= 1'b1;
                     o_Busy    <= 1'b0;
                  end
               end
               default: begin
                  state     <= S_IDLE;
                  o_Tx_line <= 1'b1;
                  o_Busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bit_fifo_tx_scheduler.sv
// Scoreboard bench: stimulus queues the expected {busy, line} per issued tick,
// a negedge monitor pops and compares, and holds the last value between ticks.
module tb_bit_fifo_tx_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n   = 1'b0;
   logic       tick_a  = 1'b0, tick_b  = 1'b0;
   logic       tx_en_a = 1'b0, tx_en_b = 1'b0;
   logic [3:0] wptr_a  = '0,   wptr_b  = '0;
   logic       mem_a [8];
   logic       mem_b [8];
   logic       data_a, data_b;

   logic [3:0] rptr_a, count_a, rptr_b, count_b;
   logic       ren_a, empty_a, line_a, busy_a, done_a;
   logic       ren_b, empty_b, line_b, busy_b, done_b;

   assign data_a = mem_a[rptr_a[2:0]];
   assign data_b = mem_b[rptr_b[2:0]];

   bit_fifo_tx_scheduler #(.DEPTH(8), .PTR_WIDTH(3), .FRAME_BITS(4), .PARITY_EN(1)) dut_a (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Tx_en(tx_en_a), .i_Bit_tick(tick_a),
      .i_b_wptr(wptr_a), .i_Fifo_data(data_a), .o_b_rptr(rptr_a), .o_R_en(ren_a),
      .o_empty(empty_a), .o_Count(count_a), .o_Tx_line(line_a), .o_Busy(busy_a),
      .o_Frame_done(done_a));

   bit_fifo_tx_scheduler #(.DEPTH(8), .PTR_WIDTH(3), .FRAME_BITS(4), .PARITY_EN(0)) dut_b (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Tx_en(tx_en_b), .i_Bit_tick(tick_b),
      .i_b_wptr(wptr_b), .i_Fifo_data(data_b), .o_b_rptr(rptr_b), .o_R_en(ren_b),
      .o_empty(empty_b), .o_Count(count_b), .o_Tx_line(line_b), .o_Busy(busy_b),
      .o_Frame_done(done_b));

   int total = 0;
   int bad   = 0;

   logic [1:0] q_a [$];
   logic [1:0] q_b [$];
   logic [1:0] last_a = 2'b01, last_b = 2'b01;
   logic       seen_a = 1'b0, seen_b = 1'b0, rst_seen = 1'b0, armed = 1'b0;
   int         ren_a_n = 0, done_a_n = 0, ren_b_n = 0, done_b_n = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endfunction

   always @(posedge clk) begin
      seen_a   <= tick_a & rst_n;
      seen_b   <= tick_b & rst_n;
      rst_seen <= ~rst_n;
   end

   always @(negedge clk) begin
      if (rst_seen) begin
         armed  = 1'b1;
         last_a = 2'b01;
         last_b = 2'b01;
      end
      if (armed) begin
         if (seen_a) begin
            if (q_a.size() == 0) begin
               total++; bad++;
               $display("FAIL a_unexpected_tick actual=tick required=none");
            end else last_a = q_a.pop_front();
         end
         if (seen_b) begin
            if (q_b.size() == 0) begin
               total++; bad++;
               $display("FAIL b_unexpected_tick actual=tick required=none");
            end else last_b = q_b.pop_front();
         end
         check("a_line", line_a, last_a[0]);
         check("a_busy", busy_a, last_a[1]);
         check("b_line", line_b, last_b[0]);
         check("b_busy", busy_b, last_b[1]);
         if (ren_a)  ren_a_n++;
         if (done_a) done_a_n++;
         if (ren_b)  ren_b_n++;
         if (done_b) done_b_n++;
      end
   end

   // Character i of each string is the expected value after tick i.
   task automatic push(input bit sel_b, input string lines, input string busys);
      for (int i = 0; i < lines.len(); i++) begin
         if (sel_b) q_b.push_back({busys[i] == 8'h31, lines[i] == 8'h31});
         else       q_a.push_back({busys[i] == 8'h31, lines[i] == 8'h31});
      end
   endtask

   task automatic ticks(input bit sel_b, input int n, input int period);
      for (int i = 0; i < n; i++) begin
         if (sel_b) tick_b = 1'b1; else tick_a = 1'b1;
         @(posedge clk); #1;
         tick_a = 1'b0;
         tick_b = 1'b0;
         for (int j = 1; j < period; j++) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic settle();
      @(posedge clk); #1;
   endtask

   task automatic summary();
      $display("test done: total=%0d bad=%0d", total, bad);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      bad++;
      summary();
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8; i++) begin
         mem_a[i] = 1'b0;
         mem_b[i] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_line",  line_a, 1);
      check("rst_busy",  busy_a, 0);
      check("rst_rptr",  rptr_a, 0);
      check("rst_ren",   ren_a, 0);
      check("rst_done",  done_a, 0);
      check("rst_empty", empty_a, 1);
      check("rst_count", count_a, 0);
      rst_n = 1'b1;
      settle();

      // Basic frame 1,0,1,1 with parity 1
      mem_a[0] = 1'b1; mem_a[1] = 1'b0; mem_a[2] = 1'b1; mem_a[3] = 1'b1;
      wptr_a = 4'd4; tx_en_a = 1'b1;
      #1;
      check("f1_count", count_a, 4);
      check("f1_empty", empty_a, 0);
      push(1'b0, "01011111", "11111110");
      ticks(1'b0, 8, 1);
      settle();
      check("f1_ren_n",  ren_a_n, 4);
      check("f1_done_n", done_a_n, 1);
      check("f1_rptr",   rptr_a, 4);
      check("f1_empty2", empty_a, 1);

      // No-parity instance, payload 0,0,0,0
      tx_en_b = 1'b1; wptr_b = 4'd4;
      push(1'b1, "0000011", "1111110");
      ticks(1'b1, 7, 1);
      settle();
      check("np_done_n", done_b_n, 1);
      check("np_ren_n",  ren_b_n, 4);
      check("np_rptr",   rptr_b, 4);

      // Only 3 bits buffered: no frame
      mem_a[4] = 1'b0; mem_a[5] = 1'b1; mem_a[6] = 1'b1;
      wptr_a = 4'd7;
      push(1'b0, "111", "000");
      ticks(1'b0, 3, 1);
      settle();
      check("short_count", count_a, 3);

      // Fill to 8 (full): two back-to-back frames 0,1,1,0 (p0) then 1,1,0,1 (p1)
      mem_a[7] = 1'b0;
      mem_a[0] = 1'b1; mem_a[1] = 1'b1; mem_a[2] = 1'b0; mem_a[3] = 1'b1;
      wptr_a = 4'd12;
      #1;
      check("full_count", count_a, 8);
      check("full_empty", empty_a, 0);
      push(1'b0, "001100101101111", "111111111111110");
      ticks(1'b0, 15, 1);
      settle();
      check("b2b_ren_n",  ren_a_n, 12);
      check("b2b_done_n", done_a_n, 3);
      check("b2b_rptr",   rptr_a, 12);
      check("b2b_count",  count_a, 0);
      check("b2b_empty",  empty_a, 1);

      // Slow ticks, write pointer wraps, enable dropped in DATA
      mem_a[4] = 1'b1; mem_a[5] = 1'b1; mem_a[6] = 1'b1; mem_a[7] = 1'b0;
      mem_a[0] = 1'b0; mem_a[1] = 1'b1; mem_a[2] = 1'b0; mem_a[3] = 1'b0;
      wptr_a = 4'd4;
      #1;
      check("wrap_count", count_a, 8);
      push(1'b0, "01110111111", "11111110000");
      ticks(1'b0, 3, 3);
      tx_en_a = 1'b0;
      ticks(1'b0, 8, 3);
      settle();
      check("slow_ren_n",  ren_a_n, 16);
      check("slow_done_n", done_a_n, 4);
      check("slow_rptr",   rptr_a, 0);
      check("slow_count",  count_a, 4);

      // Reset in the middle of DATA
      tx_en_a = 1'b1;
      push(1'b0, "001", "111");
      ticks(1'b0, 3, 1);
      check("pre_rst_rptr", rptr_a, 2);
      rst_n = 1'b0;
      settle();
      check("mrst_line", line_a, 1);
      check("mrst_rptr", rptr_a, 0);
      check("mrst_busy", busy_a, 0);
      check("mrst_done", done_a, 0);
      settle();
      check("mrst_done_n", done_a_n, 4);
      check("mrst_ren_n",  ren_a_n, 18);
      check("mrst_count",  count_a, 4);
      rst_n = 1'b1;
      settle();
      check("q_a_left", q_a.size(), 0);
      check("q_b_left", q_b.size(), 0);

      summary();
      $finish;
   end

endmodule
